// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared widths, payload layout and Tnew helper for the pipeline stage register
package pipe_stage_reg_pkg;

    localparam int A3_W_DEF      = 5;
    localparam int TNEW_W_DEF    = 2;
    localparam int CTRL_W_DEF    = 8;
    localparam int FIELD_W       = 32;
    localparam int PAYLOAD_W_DEF = 7 * FIELD_W;

    // Bit offsets of the 32-bit fields packed into the opaque payload bundle.
    localparam int ALU_OFS = 0 * FIELD_W;
    localparam int MDU_OFS = 1 * FIELD_W;
    localparam int PC4_OFS = 2 * FIELD_W;
    localparam int PC8_OFS = 3 * FIELD_W;
    localparam int E32_OFS = 4 * FIELD_W;
    localparam int DR_OFS  = 5 * FIELD_W;
    localparam int CP0_OFS = 6 * FIELD_W;

    // Callers cast the result back to their own Tnew width.
    function automatic logic [31:0] tnew_dec(input logic [31:0] t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one pipeline entry (valid/tnew/a3/we/ctrl/payload) with load, kill and Tnew decrement
module pipe_entry_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int A3_W      = A3_W_DEF,
    parameter int TNEW_W    = TNEW_W_DEF,
    parameter int CTRL_W    = CTRL_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 kill,
    input  logic                 load,
    input  logic                 dec,
    input  logic [TNEW_W-1:0]    d_tnew,
    input  logic [A3_W-1:0]      d_a3,
    input  logic                 d_we,
    input  logic [CTRL_W-1:0]    d_ctrl,
    input  logic [PAYLOAD_W-1:0] d_payload,
    output logic                 q_valid,
    output logic [TNEW_W-1:0]    q_tnew,
    output logic [A3_W-1:0]      q_a3,
    output logic                 q_we,
    output logic [CTRL_W-1:0]    q_ctrl,
    output logic [PAYLOAD_W-1:0] q_payload
);

    logic [TNEW_W-1:0] d_tnew_dec;
    logic [TNEW_W-1:0] q_tnew_dec;

    assign d_tnew_dec = TNEW_W'(tnew_dec(32'(d_tnew)));
    assign q_tnew_dec = TNEW_W'(tnew_dec(32'(q_tnew)));

    // Kill leaves ctrl/payload untouched; only the fields that matter for hazards are cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid   <= 1'b0;
            q_tnew    <= '0;
            q_a3      <= '0;
            q_we      <= 1'b0;
            q_ctrl    <= '0;
            q_payload <= '0;
        end else if (kill) begin
            q_valid <= 1'b0;
            q_tnew  <= '0;
            q_a3    <= '0;
            q_we    <= 1'b0;
        end else if (load) begin
            q_valid   <= 1'b1;
            q_tnew    <= d_tnew_dec;
            q_a3      <= d_a3;
            q_we      <= d_we;
            q_ctrl    <= d_ctrl;
            q_payload <= d_payload;
        end else if (dec) begin
            q_tnew <= q_tnew_dec;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry (main + skid) pipeline stage register with Tnew tracking and flush
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int A3_W      = A3_W_DEF,
    parameter int TNEW_W    = TNEW_W_DEF,
    parameter int CTRL_W    = CTRL_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [A3_W-1:0]      in_a3,
    input  logic                 in_we,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [A3_W-1:0]      out_a3,
    output logic                 out_we,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 fwd_ok
);

    logic                 main_valid;
    logic [TNEW_W-1:0]    main_tnew;
    logic [A3_W-1:0]      main_a3;
    logic                 main_we;

    logic                 skid_valid;
    logic [TNEW_W-1:0]    skid_tnew;
    logic [A3_W-1:0]      skid_a3;
    logic                 skid_we;
    logic [CTRL_W-1:0]    skid_ctrl;
    logic [PAYLOAD_W-1:0] skid_payload;

    logic                 xfer_in;
    logic                 xfer_out;
    logic                 main_load;
    logic                 main_kill;
    logic                 skid_load;
    logic                 skid_kill;
    logic                 skid_valid_nxt;
    logic                 in_ready_q;

    logic [TNEW_W-1:0]    main_d_tnew;
    logic [A3_W-1:0]      main_d_a3;
    logic                 main_d_we;
    logic [CTRL_W-1:0]    main_d_ctrl;
    logic [PAYLOAD_W-1:0] main_d_payload;

    assign xfer_in  = in_valid & in_ready_q;
    assign xfer_out = main_valid & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_kill      = 1'b0;
        skid_load      = 1'b0;
        skid_kill      = 1'b0;
        main_d_tnew    = in_tnew;
        main_d_a3      = in_a3;
        main_d_we      = in_we;
        main_d_ctrl    = in_ctrl;
        main_d_payload = in_payload;

        if (!main_valid) begin
            main_load = xfer_in;
        end else if (xfer_out) begin
            if (skid_valid) begin
                // Skid drains into main; in_ready was low so nothing new arrives this edge.
                main_load      = 1'b1;
                skid_kill      = 1'b1;
                main_d_tnew    = skid_tnew;
                main_d_a3      = skid_a3;
                main_d_we      = skid_we;
                main_d_ctrl    = skid_ctrl;
                main_d_payload = skid_payload;
            end else if (xfer_in) begin
                main_load = 1'b1;
            end else begin
                main_kill = 1'b1;
            end
        end else begin
            skid_load = xfer_in;
        end

        if (flush) begin
            main_kill = 1'b1;
            skid_kill = 1'b1;
        end

        if (skid_kill)
            skid_valid_nxt = 1'b0;
        else if (skid_load)
            skid_valid_nxt = 1'b1;
        else
            skid_valid_nxt = skid_valid;
    end

    // in_ready is registered so it never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            in_ready_q <= 1'b1;
        else
            in_ready_q <= ~skid_valid_nxt;
    end

    assign in_ready = in_ready_q;

    pipe_entry_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .A3_W      (A3_W),
        .TNEW_W    (TNEW_W),
        .CTRL_W    (CTRL_W)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .kill      (main_kill),
        .load      (main_load),
        .dec       (main_valid),
        .d_tnew    (main_d_tnew),
        .d_a3      (main_d_a3),
        .d_we      (main_d_we),
        .d_ctrl    (main_d_ctrl),
        .d_payload (main_d_payload),
        .q_valid   (main_valid),
        .q_tnew    (main_tnew),
        .q_a3      (main_a3),
        .q_we      (main_we),
        .q_ctrl    (out_ctrl),
        .q_payload (out_payload)
    );

    pipe_entry_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .A3_W      (A3_W),
        .TNEW_W    (TNEW_W),
        .CTRL_W    (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .kill      (skid_kill),
        .load      (skid_load),
        .dec       (skid_valid),
        .d_tnew    (in_tnew),
        .d_a3      (in_a3),
        .d_we      (in_we),
        .d_ctrl    (in_ctrl),
        .d_payload (in_payload),
        .q_valid   (skid_valid),
        .q_tnew    (skid_tnew),
        .q_a3      (skid_a3),
        .q_we      (skid_we),
        .q_ctrl    (skid_ctrl),
        .q_payload (skid_payload)
    );

    assign out_valid = main_valid;
    assign out_tnew  = main_tnew;
    assign out_a3    = main_valid ? main_a3 : '0;
    assign out_we    = main_valid & main_we;
    assign fwd_ok    = out_valid & out_we & (out_a3 != '0) & (out_tnew == '0);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 224, width of the opaque data bundle (ALU, MDU, PC4, PC8, E32, DR, CP0 read fields, concatenated).
REQ-002 Parameter A3_W, default 5, width of the destination register address.
REQ-003 Parameter TNEW_W, default 2, width of the Tnew counter.
REQ-004 Parameter CTRL_W, default 8, width of the opaque control bundle (rf_wa_sel, rf_wd_sel).
REQ-005 Ports, one per line:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept.
- in_tnew  in  TNEW_W  upstream Tnew.
- in_a3  in  A3_W  upstream destination.
- in_we  in  1  upstream register-file write enable.
- in_ctrl  in  CTRL_W  upstream control.
- in_payload  in  PAYLOAD_W  upstream data.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_tnew, out_a3, out_we, out_ctrl, out_payload  out  as inputs  presented entry.
- fwd_ok  out  1  presented result is forwardable.

Function
REQ-006 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both are evaluated at the same rising edge.
REQ-007 Storage is two entries: a main register driving the outputs and a one-entry skid register.
REQ-008 in_ready is driven from a flop and equals NOT skid_valid; it has no combinational path from out_ready.
REQ-009 Empty main, transfer in: the entry loads into main; out_valid = 1 next cycle (latency 1).
REQ-010 Main valid, transfer out, transfer in, skid empty: the new entry replaces main.
REQ-011 Main valid, no transfer out, transfer in: the entry loads into skid and in_ready falls next cycle.
REQ-012 Transfer out with skid valid: skid moves to main, skid clears, and in_ready rises next cycle.
REQ-013 Transfer out, no transfer in, skid empty: out_valid falls next cycle.
REQ-014 Tnew on capture (main or skid) = in_tnew − 1, saturating at 0.
REQ-015 Held entry (main or skid, not moved this cycle): its Tnew decrements by 1 each cycle, saturating at 0.
REQ-016 Skid-to-main move: the moved Tnew decrements by 1, saturating at 0.
REQ-017 out_we and out_a3 are forced to 0 whenever out_valid = 0.
REQ-018 fwd_ok = out_valid & out_we & (out_a3 ≠ 0) & (out_tnew = 0); combinational from the main register.
REQ-019 Flush has priority over every transfer: the next cycle main and skid are invalid, with we, a3 and tnew = 0, and in_ready = 1.
REQ-020 Flush does not require any payload or ctrl value.
REQ-021 Flush in the same cycle as transfer in: the incoming entry is discarded.
REQ-022 An entry with in_we = 0 propagates normally.
REQ-023 An entry with in_a3 = 0 propagates normally; only fwd_ok is suppressed.

Reset
REQ-024 Asserting reset immediately forces main valid, skid valid, we, a3, tnew, ctrl and payload to 0, and in_ready to 1.
REQ-025 Reset asserted mid-stall discards both entries.
REQ-026 The first capture is possible at the first rising edge after reset deasserts.

Structure
REQ-027 The shared package holds default widths (A3_W = 5, TNEW_W = 2), the Tnew saturating-decrement function, and the payload field offset constants.
REQ-028 One sub-module, pipe_entry_reg, holds a single valid/tnew/a3/we/ctrl/payload entry with load and decrement controls.
REQ-029 pipe_stage_reg instantiates pipe_entry_reg twice, once for main and once for skid.

Verification
REQ-030 Reset, then in_valid = 1, in_tnew = 2, in_a3 = 5, in_we = 1, out_ready = 1 -> next cycle out_valid = 1, out_tnew = 1, out_a3 = 5, fwd_ok = 0; one cycle later (no new input) out_valid = 0.
REQ-031 out_ready = 0, two back-to-back entries A (tnew 2) then B (tnew 1) -> main = A, skid = B, in_ready = 0; after one stall cycle A tnew = 0 and fwd_ok = 1 if A we = 1 and a3 ≠ 0.
REQ-032 From the REQ-031 state, set out_ready = 1 -> A leaves, B moves to main with tnew 0, and in_ready = 1 the next cycle.
REQ-033 Flush while main and skid are valid and in_valid = 1 -> next cycle out_valid = 0, out_we = 0, out_a3 = 0, in_ready = 1, and no entry emerges afterwards.
REQ-034 Entry with in_a3 = 0, in_we = 1, in_tnew = 0 -> out_valid = 1, out_tnew = 0, fwd_ok = 0.
REQ-035 Assert reset asynchronously between clock edges during a stall -> outputs clear before the next edge and in_ready = 1.
